// File: rtl/demux1to4_collect_pkg.sv
// Shared definitions for the 1-to-4 lane demultiplexer and its lane pointer.
package demux1to4_collect_pkg;

   localparam int NUM_SLOTS = 4;
   localparam int SEL_W     = 2;

   // Lane select shared with the 4-to-1 mux stage: 00 selects slot 0 ... 11 selects slot 3.
   typedef logic [SEL_W-1:0] lane_sel_t;

   localparam lane_sel_t SLOT_LAST = 2'd3;

   // FILL: no unconsumed word on O. FULL: O holds a word awaiting out_ack.
   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

endpackage

// File: rtl/demux1to4_collect_lane_ptr.sv
// Two-bit wrapping lane pointer with frame-sync clear and per-beat increment.
module demux1to4_collect_lane_ptr
   import demux1to4_collect_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      clear,
   input  logic      inc,
   output lane_sel_t sel,
   output logic      last
);

   // A sync that arrives with a beat puts that beat in slot 0, so the pointer lands on slot 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel <= '0;
      end else if (clear) begin
         sel <= inc ? lane_sel_t'(1) : lane_sel_t'(0);
      end else if (inc) begin
         sel <= lane_sel_t'(sel + 2'd1);
      end
   end

   assign last = (sel == SLOT_LAST);

endmodule

// File: rtl/demux1to4_collect.sv
// Rebuilds a 4-slot word from a serial lane and offers it with a valid/ack handshake.
module demux1to4_collect
   import demux1to4_collect_pkg::*;
#(
   parameter int LANE_W = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [LANE_W-1:0]           din,
   input  logic                        din_valid,
   input  logic                        sync,
   output logic [NUM_SLOTS*LANE_W-1:0] O,
   output lane_sel_t                   Sel,
   input  logic                        out_ack,
   output logic                        out_valid,
   output logic                        overrun
);

   // The last slot is never stored in the shadow: its beat goes straight into O on completion.
   logic [LANE_W-1:0]    sh [0:NUM_SLOTS-2];
   logic [NUM_SLOTS-2:0] wr_en;
   logic                 sel_last;
   logic                 complete;
   state_t               state;
   state_t               state_next;

   demux1to4_collect_lane_ptr u_lane_ptr (
      .clk   (clk),
      .reset (reset),
      .clear (sync),
      .inc   (din_valid),
      .sel   (Sel),
      .last  (sel_last)
   );

   assign complete = din_valid && !sync && sel_last;

   // Decode the shadow slot written by this beat; sync redirects the beat to slot 0.
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_SLOTS - 1; i++) begin
         wr_en[i] = din_valid && (sync ? (i == 0) : (Sel == lane_sel_t'(i)));
      end
   end

   // Shadow slots collect the partial word; stale slots are simply overwritten later.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            sh[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SLOTS - 1; i++) begin
            if (wr_en[i]) begin
               sh[i] <= din;
            end
         end
      end
   end

   // Handshake state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // A completion always leaves a word pending; an ack only empties when nothing new arrives.
   always_comb begin
      state_next = state;
      case (state)
         FILL: begin
            if (complete) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (!complete && out_ack) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   assign out_valid = (state == FULL);

   // Slot 0 sits in the most significant lane of O; O keeps its value after an ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         O <= '0;
      end else if (complete) begin
         O <= {sh[0], sh[1], sh[2], din};
      end
   end

   // Sticky flag for a new word replacing one the consumer never acknowledged.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (complete && out_valid && !out_ack) begin
         overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_demux1to4_collect.sv
// Scoreboard bench: a beat-queue reference model predicts every cycle, a monitor compares.
module tb_demux1to4_collect;

   localparam int LANE_W = 1;
   localparam int OW     = 4 * LANE_W;

   logic              clk;
   logic              reset;
   logic [LANE_W-1:0] din;
   logic              din_valid;
   logic              sync;
   logic [OW-1:0]     O;
   logic [1:0]        Sel;
   logic              out_ack;
   logic              out_valid;
   logic              overrun;

   typedef struct {
      logic [OW-1:0] o;
      logic [1:0]    sel;
      logic          valid;
      logic          ovr;
   } exp_t;

   exp_t expQ[$];

   // Reference model state: the beats of the current frame in arrival order.
   logic [LANE_W-1:0] partial[$];
   logic [OW-1:0]     mO;
   logic              mValid;
   logic              mOverrun;

   int  checks;
   int  passes;
   int  fails;
   bit  stimDone;

   demux1to4_collect #(.LANE_W(LANE_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .sync      (sync),
      .O         (O),
      .Sel       (Sel),
      .out_ack   (out_ack),
      .out_valid (out_valid),
      .overrun   (overrun)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         passes++;
      end
   endtask

   // Reference model: advance one clock edge with the given inputs and queue the expectation.
   task automatic modelStep(input logic r, input logic v, input logic [LANE_W-1:0] d,
                            input logic s, input logic a);
      bit   done;
      exp_t e;
      done = 0;
      if (r) begin
         partial.delete();
         mO       = '0;
         mValid   = 1'b0;
         mOverrun = 1'b0;
      end else begin
         if (s) partial.delete();
         if (v) begin
            partial.push_back(d);
            if (partial.size() == 4) begin
               mO   = {partial[0], partial[1], partial[2], partial[3]};
               done = 1;
               partial.delete();
            end
         end
         if (done) begin
            if (mValid && !a) mOverrun = 1'b1;
            mValid = 1'b1;
         end else if (a) begin
            mValid = 1'b0;
         end
      end
      e.o     = mO;
      e.sel   = 2'(partial.size());
      e.valid = mValid;
      e.ovr   = mOverrun;
      expQ.push_back(e);
   endtask

   // Drive one cycle of inputs, let the edge happen, then predict its result.
   task automatic applyStimulus(input logic r, input logic v, input logic [LANE_W-1:0] d,
                                input logic s, input logic a);
      reset     = r;
      din_valid = v;
      din       = d;
      sync      = s;
      out_ack   = a;
      @(posedge clk);
      modelStep(r, v, d, s, a);
      @(negedge clk);
   endtask

   task automatic beat(input logic [LANE_W-1:0] d, input logic a);
      applyStimulus(1'b0, 1'b1, d, 1'b0, a);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle the registered outputs are compared with the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("O",         32'(O),         32'(e.o));
            checkOutput("Sel",       32'(Sel),       32'(e.sel));
            checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
            checkOutput("overrun",   32'(overrun),   32'(e.ovr));
         end
      end
   end

   // Directed scenarios followed by a randomized run.
   initial begin
      int waitCycles;
      checks = 0; passes = 0; fails = 0; stimDone = 0;
      reset = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0; out_ack = 1'b0;
      mO = '0; mValid = 1'b0; mOverrun = 1'b0;
      @(negedge clk);

      $display("[TB] basic word 1001");
      doReset();
      beat(1, 0); beat(0, 0); beat(0, 0); beat(1, 0);
      idle(1);

      $display("[TB] gap in the middle of a frame, word 1011");
      doReset();
      beat(1, 0); beat(0, 0); idle(3); beat(1, 0); beat(1, 0);
      idle(1);

      $display("[TB] sync without beat discards the partial word, word 0110");
      doReset();
      beat(1, 0); beat(1, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
      beat(0, 0); beat(1, 0); beat(1, 0); beat(0, 0);
      idle(1);

      $display("[TB] unacked word replaced, overrun set, then acked");
      doReset();
      beat(1, 0); beat(0, 0); beat(0, 0); beat(0, 0);
      beat(1, 0); beat(0, 0); beat(1, 0); beat(0, 0);
      applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
      idle(2);

      $display("[TB] ack coincident with completion, no overrun");
      doReset();
      beat(1, 0); beat(0, 0); beat(0, 0); beat(1, 0);
      beat(0, 0); beat(1, 0); beat(0, 0); beat(1, 1);
      idle(1);

      $display("[TB] reset mid-frame with a beat present, word 0011");
      doReset();
      beat(1, 0); beat(1, 0);
      applyStimulus(1'b1, 1'b1, 1, 1'b0, 1'b0);
      beat(0, 0); beat(0, 0); beat(1, 0); beat(1, 0);
      idle(1);

      $display("[TB] sync together with a beat");
      beat(1, 1); beat(0, 0);
      applyStimulus(1'b0, 1'b1, 1, 1'b1, 1'b0);
      beat(1, 0); beat(0, 0); beat(1, 0);
      idle(1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(63) == 0),
                       ($urandom_range(3) != 0),
                       LANE_W'($urandom),
                       ($urandom_range(15) == 0),
                       ($urandom_range(2) == 0));
      end

      stimDone = 1;
      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 10) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
